dds_strobe_fifo: RTL and testbench

//  Downstream consumer of the DDS counter's fractional-rate enable strobe (e.g. 3-of-5).

---
 rtl/dds_pkg.sv | 18 +
 rtl/dds_strobe_ram.sv | 24 ++
 rtl/dds_strobe_fifo.sv | 118 +++++++++++
 tb/tb_dds_strobe_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types for the DDS strobe FIFO slice.
// State enum, stats width and a saturating increment helper.
package dds_pkg;

  typedef enum logic {
    ST_PREFILL = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dds_strobe_ram.sv
// DEPTH x DW sample store for the DDS strobe FIFO.
// Synchronous write port, asynchronous read port.
module dds_strobe_ram #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dds_strobe_fifo.sv
// Sample FIFO drained by a fractional-rate DDS strobe.
// Optional DDS_STROBE_STATS_EN adds strobe/underrun counters.
module dds_strobe_fifo
  import dds_pkg::*;
#(
  parameter  int DW      = 8,
  parameter  int DEPTH   = 8,
  parameter  int PREFILL = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          running,
  output logic          underrun
`ifdef DDS_STROBE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_strobes,
  output logic [STAT_W-1:0] stat_underruns
`endif
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] PF_LVL   = PREFILL[AW:0];

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] head;
  logic          wr;
  logic          strobe;
  logic          rd;
  logic          urun;

  assign in_ready = (count != FULL_LVL);
  assign wr       = in_valid && in_ready;
  assign strobe   = (state == ST_RUN) && enable;
  assign rd       = strobe && (count != '0);
  assign urun     = strobe && (count == '0);
  assign level    = count;
  assign running  = (state == ST_RUN);

  dds_strobe_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An empty strobe in RUN drops back to PREFILL to rebuild slack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_PREFILL;
    end else begin
      unique case (1'b1)
        state == ST_PREFILL:
          if (count >= PF_LVL) state <= ST_RUN;
        state == ST_RUN:
          if (urun) state <= ST_PREFILL;
        default:
          state <= ST_PREFILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      underrun  <= 1'b0;
    end else begin
      out_valid <= rd;
      underrun  <= urun;
      if (rd) out_data <= head;
    end
  end

`ifdef DDS_STROBE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_strobes   <= '0;
      stat_underruns <= '0;
    end else begin
      if (strobe) stat_strobes <= sat_inc(stat_strobes);
      if (urun) stat_underruns <= sat_inc(stat_underruns);
    end
  end
`endif

endmodule

// File: tb/tb_dds_strobe_fifo.sv
// Scoreboard bench for dds_strobe_fifo.
// Directed vectors; stats checks under DDS_STROBE_STATS_EN.
module tb_dds_strobe_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] level;
  logic       running;
  logic       underrun;
`ifdef DDS_STROBE_STATS_EN
  logic [15:0] stat_strobes;
  logic [15:0] stat_underruns;
  localparam int NLONG = 70000;
`else
  localparam int NLONG = 20;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sb [$];
  logic [7:0] wdat;
  logic [7:0] rexp;
  bit pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  dds_strobe_fifo #(
    .DW      (8),
    .DEPTH   (8),
    .PREFILL (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .running   (running),
    .underrun  (underrun)
`ifdef DDS_STROBE_STATS_EN
    ,
    .stat_strobes   (stat_strobes),
    .stat_underruns (stat_underruns)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic e, input logic [7:0] d);
    in_valid = v;
    enable   = e;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output pulse must match the oldest expected sample.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out_valid: got data %0h expected none at %0t",
                 out_data, $time);
      end else begin
        chk("out_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    #2;
    // Reset held with activity on inputs
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'(i % 2), 8'h55);
      chk("rst_level", 32'(level), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_underrun", 32'(underrun), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    enable = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_level", 32'(level), 0);

    // Prefill with enable held high
    wdat = 8'h10;
    rexp = 8'h10;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, wdat);
      wdat++;
      chk("pf_level", 32'(level), 32'(k + 1));
      chk("pf_underrun", 32'(underrun), 0);
      chk("pf_running", 32'(running), 0);
    end
    cyc(1'b1, 1'b1, wdat);
    wdat++;
    chk("pf_run_entry", 32'(running), 1);
    chk("pf_level5", 32'(level), 5);

    // 5-to-3 strobe pattern, writes matched to reads
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        if (pat[i]) begin
          sb.push_back(rexp);
          rexp++;
        end
        cyc(pat[i], pat[i], wdat);
        if (pat[i]) wdat++;
        chk("pat_out_valid", 32'(out_valid), 32'(pat[i]));
        chk("pat_level", 32'(level), 5);
      end
    end

    // Drain then underrun
    for (int i = 0; i < 5; i++) begin
      sb.push_back(rexp);
      rexp++;
      cyc(1'b0, 1'b1, 8'h00);
      chk("drain_out_valid", 32'(out_valid), 1);
    end
    chk("drain_level", 32'(level), 0);
    chk("drain_running", 32'(running), 1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("ur_pulse", 32'(underrun), 1);
    chk("ur_out_valid", 32'(out_valid), 0);
    chk("ur_running", 32'(running), 0);
    cyc(1'b0, 1'b1, 8'h00);
    chk("ur_one_cycle", 32'(underrun), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, wdat);
      wdat++;
      chk("refill_underrun", 32'(underrun), 0);
      chk("refill_running", 32'(running), 0);
    end
    chk("refill_level", 32'(level), 3);

    // Fill to full, then free one slot with a strobe
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, wdat);
      wdat++;
    end
    chk("full_level", 32'(level), 8);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_running", 32'(running), 1);
    cyc(1'b1, 1'b0, 8'hAA);
    chk("full_no_ovf", 32'(level), 8);
    sb.push_back(rexp);
    rexp++;
    cyc(1'b1, 1'b1, 8'hAB);
    chk("full_rd_level", 32'(level), 7);
    chk("full_rd_in_ready", 32'(in_ready), 1);
    cyc(1'b1, 1'b0, wdat);
    wdat++;
    chk("ninth_level", 32'(level), 8);
    chk("ninth_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(rexp);
      rexp++;
      cyc(1'b0, 1'b1, 8'h00);
    end
    chk("pre_rst_level", 32'(level), 5);
    chk("pre_rst_out_valid", 32'(out_valid), 1);
`ifdef DDS_STROBE_STATS_EN
    chk("stat_strobes", 32'(stat_strobes), 16);
    chk("stat_underruns", 32'(stat_underruns), 1);
`endif

    // Asynchronous reset mid-run
    enable = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_level", 32'(level), 0);
    chk("mr_running", 32'(running), 0);
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_out_data", 32'(out_data), 0);
    chk("mr_in_ready", 32'(in_ready), 1);
    chk("mr_sb_empty", 32'(sb.size()), 0);
`ifdef DDS_STROBE_STATS_EN
    chk("mr_stat_strobes", 32'(stat_strobes), 0);
    chk("mr_stat_underruns", 32'(stat_underruns), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Long streaming run after reset
    wdat = 8'h40;
    rexp = 8'h40;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, wdat);
      wdat++;
    end
    chk("long_running", 32'(running), 1);
    for (int i = 0; i < NLONG; i++) begin
      sb.push_back(rexp);
      rexp++;
      cyc(1'b1, 1'b1, wdat);
      wdat++;
    end
    chk("long_level", 32'(level), 5);
`ifdef DDS_STROBE_STATS_EN
    chk("stat_sat", 32'(stat_strobes), 32'hFFFF);
    chk("stat_ur_zero", 32'(stat_underruns), 0);
`endif
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
